// File: rtl/bridge_tx.sv
// Read-response serialiser: queues read data from the bus chain and emits each word
// to a byte-wide UART as "M", four uppercase hex digits, CR, LF.
module bridge_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_i,
    input  logic        rw_i,
    input  logic        valid_i,
    output logic [7:0]  data_o,
    output logic        start_o,
    input  logic        done_i,
    output logic        busy_o,
    output logic        overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t        state_q;
    logic [2:0]    idx_q;
    logic [15:0]   word_q;
    logic [7:0]    data_q;
    logic          start_q;
    logic          busy_q;
    logic          overflow_q;

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;

    logic          rd_req, full, push, pop, drop, frame_end, busy_d;
    logic [15:0]   head;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] frame_byte(input logic [15:0] w, input logic [2:0] i);
        case (i)
            3'd0:    return 8'h4D;
            3'd1:    return hex_char(w[15:12]);
            3'd2:    return hex_char(w[11:8]);
            3'd3:    return hex_char(w[7:4]);
            3'd4:    return hex_char(w[3:0]);
            3'd5:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    // A pop frees a slot in the same cycle, so a full queue still accepts a push then.
    always_comb begin
        rd_req    = valid_i && !rw_i;
        full      = (count_q == CW'(FIFO_DEPTH));
        pop       = (state_q == IDLE) && (count_q != '0);
        push      = rd_req && (!full || pop);
        drop      = rd_req && full && !pop;
        count_d   = count_q + CW'(push) - CW'(pop);
        head      = mem_q[rd_ptr_q];
        frame_end = (state_q == WAIT) && done_i && (idx_q == 3'd6);
        busy_d    = pop || ((state_q != IDLE) && !frame_end) || (count_d != '0);
    end

    // NOTE: queue storage carries no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (drop) overflow_q <= 1'b1;
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        word_q  <= head;
                        idx_q   <= '0;
                        data_q  <= frame_byte(head, 3'd0);
                        start_q <= 1'b1;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    start_q <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (done_i) begin
                        if (idx_q == 3'd6) begin
                            state_q <= IDLE;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            data_q  <= frame_byte(word_q, idx_q + 3'd1);
                            start_q <= 1'b1;
                            state_q <= SEND;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_o     = data_q;
    assign start_o    = start_q;
    assign busy_o     = busy_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_bridge_tx.sv
// Directed bench for bridge_tx: table of single transactions plus hand-written
// back-to-back, overflow and reset-mid-frame sequences.
module tb_bridge_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_i;
    logic        rw_i;
    logic        valid_i;
    logic [7:0]  data_o;
    logic        start_o;
    logic        done_i;
    logic        busy_o;
    logic        overflow_o;

    logic        auto_done = 1'b0;
    logic        man_done  = 1'b0;
    logic        auto_en   = 1'b1;
    logic        busy_seen = 1'b0;
    int          dcnt = 0;
    int          cyc = 0;
    int          last_valid_cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [7:0]  cap_q[$];
    int          start_cyc[$];

    assign done_i = auto_done | man_done;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bridge_tx #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .rw_i       (rw_i),
        .valid_i    (valid_i),
        .data_o     (data_o),
        .start_o    (start_o),
        .done_i     (done_i),
        .busy_o     (busy_o),
        .overflow_o (overflow_o)
    );

    // UART stand-in: log every start, answer with done_i three cycles later.
    always @(negedge clk) begin
        auto_done = 1'b0;
        if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) auto_done = 1'b1;
        end
        if (busy_o) busy_seen = 1'b1;
        if (start_o) begin
            cap_q.push_back(data_o);
            start_cyc.push_back(cyc);
            if (auto_en) dcnt = 3;
        end
    end

    typedef struct {
        logic [15:0] data;
        logic        rw;
        logic        stray;
        logic [55:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send(input logic rw, input logic [15:0] d);
        valid_i = 1'b1;
        rw_i    = rw;
        data_i  = d;
        last_valid_cyc = cyc;
        tick();
        valid_i = 1'b0;
        rw_i    = 1'b0;
    endtask

    task automatic clear_log();
        cap_q.delete();
        start_cyc.delete();
        busy_seen = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget, input string name);
        int k = 0;
        while ((cap_q.size() < n || busy_o) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) begin
            total++;
            bad++;
            $display("FAIL %s: timeout with %0d bytes, required %0d", name, cap_q.size(), n);
        end
    endtask

    function automatic logic [55:0] frame_at(input int base);
        logic [55:0] f = '0;
        for (int i = 0; i < 7; i++) begin
            f = {f[47:0], (base + i < cap_q.size()) ? cap_q[base + i] : 8'hXX};
        end
        return f;
    endfunction

    function automatic logic [55:0] digit_frame(input logic [7:0] d);
        return {8'h4D, d, d, d, d, 8'h0D, 8'h0A};
    endfunction

    initial begin
        vecs[0] = '{16'hBEEF, 1'b0, 1'b0, 56'h4D_42_45_45_46_0D_0A};
        vecs[1] = '{16'h1234, 1'b1, 1'b0, 56'h0};
        vecs[2] = '{16'hA5A5, 1'b0, 1'b1, 56'h4D_41_35_41_35_0D_0A};
        vecs[3] = '{16'hFA09, 1'b0, 1'b0, 56'h4D_46_41_30_39_0D_0A};
        vecs[4] = '{16'h8000, 1'b0, 1'b1, 56'h4D_38_30_30_30_0D_0A};

        rst = 1'b1; valid_i = 1'b0; rw_i = 1'b0; data_i = '0;
        repeat (3) tick();
        check("reset data_o", 64'(data_o), 64'h0);
        check("reset start_o", 64'(start_o), 64'h0);
        check("reset busy_o", 64'(busy_o), 64'h0);
        check("reset overflow_o", 64'(overflow_o), 64'h0);
        rst = 1'b0;
        tick();

        // Single transactions, including writes and stray done_i pulses in IDLE.
        for (int v = 0; v < 5; v++) begin
            clear_log();
            if (vecs[v].stray) begin
                man_done = 1'b1;
                tick();
                man_done = 1'b0;
                tick();
            end
            send(vecs[v].rw, vecs[v].data);
            if (vecs[v].rw) begin
                repeat (20) tick();
                check($sformatf("vec%0d write bytes", v), 64'(cap_q.size()), 64'd0);
                check($sformatf("vec%0d write busy", v), 64'(busy_seen), 64'd0);
            end else begin
                wait_bytes(7, 100, $sformatf("vec%0d wait", v));
                repeat (5) tick();
                check($sformatf("vec%0d byte count", v), 64'(cap_q.size()), 64'd7);
                check($sformatf("vec%0d frame", v), 64'(frame_at(0)), 64'(vecs[v].exp));
                check($sformatf("vec%0d latency", v), 64'(start_cyc[0] - last_valid_cyc), 64'd2);
                check($sformatf("vec%0d byte spacing", v), 64'(start_cyc[1] - start_cyc[0]), 64'd4);
                check($sformatf("vec%0d busy seen", v), 64'(busy_seen), 64'd1);
                check($sformatf("vec%0d busy after", v), 64'(busy_o), 64'd0);
            end
        end

        // Back-to-back reads: frames in order, 'M' restarts 2 cycles after final done_i.
        clear_log();
        send(1'b0, 16'h0000);
        send(1'b0, 16'h09AF);
        wait_bytes(14, 200, "b2b wait");
        check("b2b byte count", 64'(cap_q.size()), 64'd14);
        check("b2b frame0", 64'(frame_at(0)), 64'h4D_30_30_30_30_0D_0A);
        check("b2b frame1", 64'(frame_at(7)), 64'h4D_30_39_41_46_0D_0A);
        check("b2b gap", 64'(start_cyc[7] - start_cyc[6]), 64'd5);

        // Overflow: six reads while the UART is held off.
        clear_log();
        auto_en = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            valid_i = 1'b1;
            rw_i    = 1'b0;
            data_i  = {4{4'(k)}};
            tick();
        end
        valid_i = 1'b0;
        repeat (3) tick();
        check("ovf sticky set", 64'(overflow_o), 64'd1);
        check("ovf one in flight", 64'(cap_q.size()), 64'd1);
        check("ovf busy", 64'(busy_o), 64'd1);
        auto_en  = 1'b1;
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        wait_bytes(35, 400, "ovf wait");
        repeat (20) tick();
        check("ovf byte count", 64'(cap_q.size()), 64'd35);
        for (int f = 0; f < 5; f++) begin
            check($sformatf("ovf frame%0d", f), 64'(frame_at(7 * f)), 64'(digit_frame(8'h31 + 8'(f))));
        end
        check("ovf still set", 64'(overflow_o), 64'd1);

        // Reset after the third done_i of a frame truncates it.
        clear_log();
        send(1'b0, 16'hBEEF);
        begin
            int k = 0;
            while (cap_q.size() < 4 && k < 100) begin
                tick();
                k++;
            end
            check("rst reached byte 3", 64'(cap_q.size()), 64'd4);
        end
        rst = 1'b1;
        tick();
        check("rst start_o", 64'(start_o), 64'd0);
        check("rst busy_o", 64'(busy_o), 64'd0);
        check("rst overflow_o", 64'(overflow_o), 64'd0);
        rst = 1'b0;
        repeat (30) tick();
        check("rst no more starts", 64'(cap_q.size()), 64'd4);
        clear_log();
        send(1'b0, 16'h00FF);
        wait_bytes(7, 100, "rst new read wait");
        check("rst new frame", 64'(frame_at(0)), 64'h4D_30_30_46_46_0D_0A);
        check("rst new latency", 64'(start_cyc[0] - last_valid_cyc), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
